wb_master_bridge: RTL and testbench
===================================

WB_MASTER_BRIDGE -- requirements
Module: wb_master_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning bus address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning bus data width; select width = DATA_WIDTH/8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning maximum BUS-state cycles without ack/err (1..255; 8-bit counter).
REQ-004 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port: arst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port: i_start_read  input  1  CPU read request, level, held until o_done.
REQ-007 SHALL have port: i_start_write  input  1  CPU write request, level, held until o_done.
REQ-008 SHALL have port: i_addr  input  ADDR_WIDTH  request address.
REQ-009 SHALL have port: i_write_data  input  DATA_WIDTH  write data.
REQ-010 SHALL have port: i_sel  input  DATA_WIDTH/8  byte select.
REQ-011 SHALL have port: o_read_data  output  DATA_WIDTH  last completed read data.
REQ-012 SHALL have port: o_done  output  1  one-cycle completion pulse to CPU.
REQ-013 SHALL have port: o_err  output  1  one-cycle error pulse, coincident with o_done.
REQ-014 SHALL have ports: o_wb_cyc, o_wb_stb, o_wb_we  output  1 each  Wishbone classic master controls.
REQ-015 SHALL have ports: o_wb_adr  output  ADDR_WIDTH, o_wb_dat  output  DATA_WIDTH, o_wb_sel  output  DATA_WIDTH/8  Wishbone address, write data, select.
REQ-016 SHALL have ports: i_wb_dat  input  DATA_WIDTH, i_wb_ack  input  1, i_wb_err  input  1  Wishbone slave responses.

Function
REQ-017 SHALL implement FSM states IDLE, BUS, DONE; all outputs registered.
REQ-018 IDLE: if i_start_write or i_start_read is sampled high, SHALL latch i_addr/i_write_data/i_sel, set we = i_start_write, and go to BUS.
REQ-019 Simultaneous read and write requests: write SHALL win; read is not issued.
REQ-020 BUS: o_wb_cyc = o_wb_stb = 1; adr/dat/sel/we SHALL hold latched values, stable regardless of input changes.
REQ-021 BUS: on i_wb_ack SHALL go to DONE; on a read, SHALL capture i_wb_dat into o_read_data on the same edge.
REQ-022 BUS: on i_wb_err (priority over ack if both high) SHALL go to DONE with error flagged; o_read_data SHALL NOT change.
REQ-023 BUS: timeout counter SHALL clear on entry and increment each cycle; at TIMEOUT_CYCLES with no ack/err, SHALL go to DONE with error flagged.
REQ-024 DONE: o_done = 1 for exactly one cycle, o_err = 1 if flagged; cyc/stb = 0; next state SHALL be IDLE unconditionally.
REQ-025 A request still high in the IDLE cycle after DONE SHALL be treated as a new transfer (supports back-to-back burst beats from the cache transfer unit with updated address).
REQ-026 Latency: request sampled at edge N -> cyc/stb high from cycle N+1; ack sampled at edge M -> o_done high in cycle M+1; minimum 3 cycles request-to-request.
REQ-027 i_wb_ack/i_wb_err outside BUS SHALL be ignored.
REQ-028 Request dropped during BUS SHALL NOT abort the bus cycle; it completes normally and o_done still pulses.
REQ-029 o_wb_dat and o_wb_sel SHALL be driven from latched values on reads as well; slave ignores them.

Reset
REQ-030 arst high at a rising edge SHALL force IDLE, cyc/stb/we/o_done/o_err = 0, o_read_data/adr/dat/sel = 0, timeout counter = 0.
REQ-031 arst asserted mid-BUS SHALL drop cyc/stb on the next edge with no o_done pulse; no pending state survives.

Verification
REQ-032 Read: addr 0x0000_1000, ack after 2 wait cycles with i_wb_dat 0xDEAD_BEEF -> o_done one cycle, o_read_data 0xDEAD_BEEF, o_err 0.
REQ-033 Write: addr 0x0000_2004, data 0x1234_5678, sel 0xF, ack next cycle -> o_wb_we 1 with stable adr/dat/sel through BUS, o_done one cycle.
REQ-034 Burst: i_start_read held 8 beats, addr +4 after each o_done, immediate ack -> 8 bus cycles, 8 o_done pulses, 3-cycle spacing.
REQ-035 Error/timeout: i_wb_err on read -> o_done + o_err, o_read_data unchanged; no response with TIMEOUT_CYCLES=4 -> o_done + o_err after 4 BUS cycles.
REQ-036 Corner: read and write both high -> write issued; arst mid-BUS -> cyc/stb 0 next cycle, no o_done; stray ack in IDLE -> no effect.

Source files
------------

// File: rtl/wb_master_bridge.sv
// Wishbone classic single-transfer master driven by a level-held CPU read/write request.
// Runs one bus cycle per request, with an error/timeout path and a one-cycle completion pulse.
module wb_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic                    i_start_read,
    input  logic                    i_start_write,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic [DATA_WIDTH-1:0]   i_write_data,
    input  logic [DATA_WIDTH/8-1:0] i_sel,
    output logic [DATA_WIDTH-1:0]   o_read_data,
    output logic                    o_done,
    output logic                    o_err,
    output logic                    o_wb_cyc,
    output logic                    o_wb_stb,
    output logic                    o_wb_we,
    output logic [ADDR_WIDTH-1:0]   o_wb_adr,
    output logic [DATA_WIDTH-1:0]   o_wb_dat,
    output logic [DATA_WIDTH/8-1:0] o_wb_sel,
    input  logic [DATA_WIDTH-1:0]   i_wb_dat,
    input  logic                    i_wb_ack,
    input  logic                    i_wb_err
);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    // The counter value on the last allowed BUS cycle; the count starts at 0 on entry.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    logic [7:0] timeout_cnt;

    always_ff @(posedge clk) begin
        if (arst) begin
            state       <= IDLE;
            timeout_cnt <= '0;
            o_read_data <= '0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_wb_we     <= 1'b0;
            o_wb_adr    <= '0;
            o_wb_dat    <= '0;
            o_wb_sel    <= '0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            case (state)
                IDLE: begin
                    // Write wins when both requests are up.
                    if (i_start_write || i_start_read) begin
                        o_wb_adr    <= i_addr;
                        o_wb_dat    <= i_write_data;
                        o_wb_sel    <= i_sel;
                        o_wb_we     <= i_start_write;
                        o_wb_cyc    <= 1'b1;
                        o_wb_stb    <= 1'b1;
                        timeout_cnt <= '0;
                        state       <= BUS;
                    end
                end
                BUS: begin
                    if (i_wb_err || i_wb_ack || (timeout_cnt == TIMEOUT_LAST)) begin
                        o_wb_cyc <= 1'b0;
                        o_wb_stb <= 1'b0;
                        o_done   <= 1'b1;
                        // Anything other than a clean ack (error or timeout) is flagged.
                        o_err    <= i_wb_err || !i_wb_ack;
                        if (!i_wb_err && i_wb_ack && !o_wb_we) begin
                            o_read_data <= i_wb_dat;
                        end
                        state <= DONE;
                    end else begin
                        timeout_cnt <= timeout_cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Self-checking bench for wb_master_bridge: a responding slave model plus a scoreboard of
// expected completions (read data, error flag) pushed when each request is raised.
module tb_wb_master_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    localparam int K_ACK  = 0;
    localparam int K_ERR  = 1;
    localparam int K_NONE = 2;
    localparam int K_BOTH = 3;

    logic          clk;
    logic          arst;
    logic          i_start_read;
    logic          i_start_write;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_write_data;
    logic [SW-1:0] i_sel;
    logic [DW-1:0] o_read_data;
    logic          o_done;
    logic          o_err;
    logic          o_wb_cyc;
    logic          o_wb_stb;
    logic          o_wb_we;
    logic [AW-1:0] o_wb_adr;
    logic [DW-1:0] o_wb_dat;
    logic [SW-1:0] o_wb_sel;
    logic [DW-1:0] i_wb_dat;
    logic          i_wb_ack;
    logic          i_wb_err;

    wb_master_bridge #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .arst(arst),
        .i_start_read(i_start_read),
        .i_start_write(i_start_write),
        .i_addr(i_addr),
        .i_write_data(i_write_data),
        .i_sel(i_sel),
        .o_read_data(o_read_data),
        .o_done(o_done),
        .o_err(o_err),
        .o_wb_cyc(o_wb_cyc),
        .o_wb_stb(o_wb_stb),
        .o_wb_we(o_wb_we),
        .o_wb_adr(o_wb_adr),
        .o_wb_dat(o_wb_dat),
        .o_wb_sel(o_wb_sel),
        .i_wb_dat(i_wb_dat),
        .i_wb_ack(i_wb_ack),
        .i_wb_err(i_wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] model_rdata;

    // Slave model settings, changed by the tests only while the bridge is idle.
    int            resp_kind = K_ACK;
    int            ack_wait  = 0;
    int            wait_cnt  = 0;
    logic [DW-1:0] slave_rdata = '0;
    logic          stray = 1'b0;

    always @(negedge clk) begin
        if (o_wb_cyc && o_wb_stb) begin
            if (resp_kind != K_NONE && wait_cnt >= ack_wait) begin
                i_wb_ack = (resp_kind == K_ACK) || (resp_kind == K_BOTH);
                i_wb_err = (resp_kind == K_ERR) || (resp_kind == K_BOTH);
                i_wb_dat = slave_rdata;
                wait_cnt = 0;
            end else begin
                i_wb_ack = 1'b0;
                i_wb_err = 1'b0;
                wait_cnt = wait_cnt + 1;
            end
        end else begin
            i_wb_ack = stray;
            i_wb_err = stray;
            i_wb_dat = slave_rdata;
            wait_cnt = 0;
        end
    end

    // Waits (bounded) for o_done; ncyc counts negedges since the call.
    task automatic wait_done(output bit seen, output int ncyc);
        seen = 1'b0;
        ncyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            ncyc++;
            if (o_done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic release_req();
        i_start_read  = 1'b0;
        i_start_write = 1'b0;
    endtask

    task automatic test_reset();
        arst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_wb_cyc, o_wb_stb, o_wb_we, o_done, o_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got cyc/stb/we/done/err=%b want 00000",
                     {o_wb_cyc, o_wb_stb, o_wb_we, o_done, o_err});
        end
        checks++;
        if ({o_read_data, o_wb_adr, o_wb_dat, o_wb_sel} !== '0) begin
            errors++;
            $display("FAIL reset_data got rd=%h adr=%h dat=%h sel=%h want all zero",
                     o_read_data, o_wb_adr, o_wb_dat, o_wb_sel);
        end
        arst = 1'b0;
        model_rdata = '0;
        @(negedge clk);
    endtask

    // Pops the scoreboard and compares it against the current completion.
    task automatic test_completion(input string name, input bit seen);
        exp_t e;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_done got no o_done within budget want pulse", name);
            release_req();
            return;
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_sb got o_done with empty scoreboard want queued entry", name);
            return;
        end
        e = exp_q.pop_front();
        checks++;
        if (o_read_data !== e.rdata) begin
            errors++;
            $display("FAIL %s_rdata got %h want %h", name, o_read_data, e.rdata);
        end
        checks++;
        if (o_err !== e.err) begin
            errors++;
            $display("FAIL %s_err got %b want %b", name, o_err, e.err);
        end
    endtask

    task automatic test_read();
        bit seen;
        int ncyc;
        resp_kind = K_ACK; ack_wait = 2; slave_rdata = 32'hDEAD_BEEF;
        i_addr = 32'h0000_1000; i_start_read = 1'b1;
        model_rdata = 32'hDEAD_BEEF;
        exp_q.push_back('{rdata: model_rdata, err: 1'b0});
        wait_done(seen, ncyc);
        release_req();
        test_completion("read", seen);
        checks++;
        if (ncyc != 4) begin
            errors++;
            $display("FAIL read_latency got %0d want 4", ncyc);
        end
        @(negedge clk);
        checks++;
        if (o_done !== 1'b0 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL read_pulse_width got done=%b err=%b want 0 0", o_done, o_err);
        end
    endtask

    task automatic test_write();
        bit seen;
        seen = 1'b0;
        resp_kind = K_ACK; ack_wait = 0;
        i_addr = 32'h0000_2004; i_write_data = 32'h1234_5678; i_sel = 4'hF;
        i_start_write = 1'b1;
        exp_q.push_back('{rdata: model_rdata, err: 1'b0});
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (o_done) begin
                seen = 1'b1;
            end else if (o_wb_cyc) begin
                checks++;
                if ({o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel} !==
                    {1'b1, 1'b1, 32'h0000_2004, 32'h1234_5678, 4'hF}) begin
                    errors++;
                    $display("FAIL write_bus got stb=%b we=%b adr=%h dat=%h sel=%h want 1 1 00002004 12345678 f",
                             o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel);
                end
                i_addr = 32'hFFFF_FFF0; i_write_data = 32'h0BAD_0BAD; i_sel = 4'h3;
            end
        end
        release_req();
        test_completion("write", seen);
        @(negedge clk);
        // Slow write with inputs scrambled during BUS: latched fields must hold.
        ack_wait = 3;
        i_addr = 32'h0000_2008; i_write_data = 32'hCAFE_F00D; i_sel = 4'h5;
        i_start_write = 1'b1;
        exp_q.push_back('{rdata: model_rdata, err: 1'b0});
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (o_done) begin
                seen = 1'b1;
            end else if (o_wb_cyc) begin
                checks++;
                if ({o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel} !==
                    {1'b1, 32'h0000_2008, 32'hCAFE_F00D, 4'h5}) begin
                    errors++;
                    $display("FAIL write_hold got we=%b adr=%h dat=%h sel=%h want 1 00002008 cafef00d 5",
                             o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel);
                end
                i_addr = $urandom; i_write_data = $urandom; i_sel = 4'($urandom);
            end
        end
        release_req();
        test_completion("write_slow", seen);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit seen;
        int ncyc;
        int pulses = 0;
        resp_kind = K_ACK; ack_wait = 0;
        i_start_read = 1'b1;
        for (int b = 0; b < 8; b++) begin
            i_addr = 32'h0000_3000 + 32'(4 * b);
            slave_rdata = 32'hA000_0000 + 32'(b);
            model_rdata = slave_rdata;
            exp_q.push_back('{rdata: model_rdata, err: 1'b0});
            wait_done(seen, ncyc);
            if (seen) pulses++;
            test_completion("burst", seen);
            checks++;
            if (ncyc != ((b == 0) ? 2 : 3)) begin
                errors++;
                $display("FAIL burst_spacing beat %0d got %0d want %0d", b, ncyc, (b == 0) ? 2 : 3);
            end
            checks++;
            if (o_wb_adr !== 32'h0000_3000 + 32'(4 * b)) begin
                errors++;
                $display("FAIL burst_adr beat %0d got %h want %h", b, o_wb_adr, 32'h0000_3000 + 32'(4 * b));
            end
        end
        release_req();
        checks++;
        if (pulses != 8) begin
            errors++;
            $display("FAIL burst_pulses got %0d want 8", pulses);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_error();
        bit seen;
        int ncyc;
        resp_kind = K_ERR; ack_wait = 1; slave_rdata = 32'h5555_5555;
        i_addr = 32'h0000_4000; i_start_read = 1'b1;
        exp_q.push_back('{rdata: model_rdata, err: 1'b1});
        wait_done(seen, ncyc);
        release_req();
        test_completion("err", seen);
        @(negedge clk);
        resp_kind = K_BOTH; ack_wait = 0; slave_rdata = 32'h6666_6666;
        i_addr = 32'h0000_4004; i_start_read = 1'b1;
        exp_q.push_back('{rdata: model_rdata, err: 1'b1});
        wait_done(seen, ncyc);
        release_req();
        test_completion("err_over_ack", seen);
        @(negedge clk);
    endtask

    task automatic test_timeout();
        bit seen;
        int ncyc;
        resp_kind = K_NONE; slave_rdata = 32'h7777_0000;
        i_addr = 32'h0000_5000; i_start_read = 1'b1;
        exp_q.push_back('{rdata: model_rdata, err: 1'b1});
        wait_done(seen, ncyc);
        release_req();
        test_completion("timeout", seen);
        checks++;
        if (ncyc != TO + 1) begin
            errors++;
            $display("FAIL timeout_latency got %0d want %0d", ncyc, TO + 1);
        end
        @(negedge clk);
    endtask

    task automatic test_both_requests();
        bit seen;
        int ncyc;
        resp_kind = K_ACK; ack_wait = 1; slave_rdata = 32'h8888_8888;
        i_addr = 32'h0000_6000; i_write_data = 32'h0102_0304; i_sel = 4'h9;
        i_start_read = 1'b1; i_start_write = 1'b1;
        exp_q.push_back('{rdata: model_rdata, err: 1'b0});
        @(negedge clk);
        checks++;
        if ({o_wb_cyc, o_wb_we, o_wb_dat} !== {1'b1, 1'b1, 32'h0102_0304}) begin
            errors++;
            $display("FAIL both_we got cyc=%b we=%b dat=%h want 1 1 01020304", o_wb_cyc, o_wb_we, o_wb_dat);
        end
        wait_done(seen, ncyc);
        release_req();
        test_completion("both", seen);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_bus();
        int done_seen = 0;
        resp_kind = K_NONE;
        i_addr = 32'h0000_7000; i_start_read = 1'b1;
        repeat (2) @(negedge clk);
        arst = 1'b1;
        @(negedge clk);
        checks++;
        if ({o_wb_cyc, o_wb_stb, o_done} !== 3'b000) begin
            errors++;
            $display("FAIL rst_mid_bus got cyc/stb/done=%b want 000", {o_wb_cyc, o_wb_stb, o_done});
        end
        release_req();
        arst = 1'b0;
        model_rdata = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (o_done || o_wb_cyc) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL rst_no_done got %0d busy/done cycles want 0", done_seen);
        end
    endtask

    task automatic test_stray_ack();
        int bad = 0;
        slave_rdata = 32'h9999_9999;
        stray = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (o_done || o_err || o_wb_cyc) bad++;
        end
        stray = 1'b0;
        @(negedge clk);
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stray_ack got %0d active cycles want 0", bad);
        end
        checks++;
        if (o_read_data !== model_rdata) begin
            errors++;
            $display("FAIL stray_rdata got %h want %h", o_read_data, model_rdata);
        end
    endtask

    initial begin
        arst = 1'b1;
        i_start_read = 1'b0; i_start_write = 1'b0;
        i_addr = '0; i_write_data = '0; i_sel = '0;
        i_wb_dat = '0; i_wb_ack = 1'b0; i_wb_err = 1'b0;
        model_rdata = '0;
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_error();
        test_timeout();
        test_both_requests();
        test_reset_mid_bus();
        test_stray_ack();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
